// File: rtl/if_fetch.sv
// Instruction fetch: PC + one-word mem request/done handshake feeding IF/ID; if_valid one edge after mem_done.
// Backpressure: stall_in holds the presented word and withholds the next request; rdy=0 freezes everything.
module if_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              stall_in,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [INST_W-1:0] mem_data,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic              req_n;
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W-1:0] ipc_n;
    logic [INST_W-1:0] inst_n;
    logic              vld_n;
    logic [ADDR_W-1:0] br_pc;

    logic unused_br_lsb;
    assign unused_br_lsb = ^br_target[1:0];

    assign br_pc = {br_target[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            if_pc    <= '0;
            if_inst  <= '0;
            if_valid <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            mem_req  <= req_n;
            mem_addr <= addr_n;
            if_pc    <= ipc_n;
            if_inst  <= inst_n;
            if_valid <= vld_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = mem_req;
        addr_n  = mem_addr;
        ipc_n   = if_pc;
        inst_n  = if_inst;
        vld_n   = if_valid;

        if (rdy) begin
            if (br_taken) begin
                pc_n  = br_pc;
                vld_n = 1'b0;
                case (state)
                    S_WAIT: begin
                        // an outstanding request must run to mem_done before it can be dropped
                        if (mem_done) begin
                            req_n   = 1'b0;
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_DROP;
                        end
                    end
                    S_DROP:  state_n = S_DROP;
                    default: state_n = S_IDLE;
                endcase
            end else begin
                case (state)
                    S_IDLE: begin
                        req_n   = 1'b1;
                        addr_n  = pc;
                        state_n = S_WAIT;
                    end
                    S_WAIT: begin
                        if (mem_done) begin
                            inst_n  = mem_data;
                            ipc_n   = pc;
                            vld_n   = 1'b1;
                            pc_n    = pc + ADDR_W'(4);
                            req_n   = 1'b0;
                            state_n = S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (!stall_in) begin
                            vld_n   = 1'b0;
                            req_n   = 1'b1;
                            addr_n  = pc;
                            state_n = S_WAIT;
                        end
                    end
                    S_DROP: begin
                        if (mem_done) begin
                            req_n   = 1'b0;
                            state_n = S_IDLE;
                        end
                    end
                    default: state_n = S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: table-driven fetches with a scoreboard, plus redirect, wrap, rdy and reset sequences.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        stall_in;
    logic        br_taken;
    logic [31:0] br_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          lat;
        int          stall;
        logic [31:0] addr;
    } vec_t;
    vec_t vecs[3];

    if_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .stall_in  (stall_in),
        .br_taken  (br_taken),
        .br_target (br_target),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_done  (mem_done),
        .mem_data  (mem_data),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .if_valid  (if_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0013 : ~a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic wait_req();
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_timeout", {31'b0, mem_req}, 32'd1);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("if_pc", if_pc, e.pc);
            chk("if_inst", if_inst, e.inst);
        end
    endtask

    task automatic complete(input logic [31:0] a);
        mem_done = 1'b1;
        mem_data = inst_of(a);
        sb.push_back({a, inst_of(a)});
        tick();
        mem_done = 1'b0;
        mem_data = 32'h0;
        chk("valid_rise", {31'b0, if_valid}, 32'd1);
        pop_check();
        chk("req_after_done", {31'b0, mem_req}, 32'd0);
    endtask

    task automatic fetch(input int lat, input int stall, input logic [31:0] a);
        logic [31:0] nxt;
        nxt = a + 32'd4;
        wait_req();
        chk("mem_addr", mem_addr, a);
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("req_held", {31'b0, mem_req}, 32'd1);
        end
        complete(a);
        if (stall > 0) stall_in = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", {31'b0, if_valid}, 32'd1);
            chk("stall_pc", if_pc, a);
            chk("stall_inst", if_inst, inst_of(a));
            chk("stall_req", {31'b0, mem_req}, 32'd0);
        end
        stall_in = 1'b0;
        tick();
        chk("consume_valid", {31'b0, if_valid}, 32'd0);
        chk("next_req", {31'b0, mem_req}, 32'd1);
        chk("next_addr", mem_addr, nxt);
    endtask

    initial begin
        vecs[0] = '{lat: 3, stall: 0, addr: 32'h0};
        vecs[1] = '{lat: 1, stall: 5, addr: 32'h4};
        vecs[2] = '{lat: 2, stall: 1, addr: 32'h8};

        rst = 1'b0; rdy = 1'b1; stall_in = 1'b0; br_taken = 1'b0;
        br_target = 32'h0; mem_done = 1'b0; mem_data = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        #4 rst = 1'b1;
        tick();
        chk("first_req", {31'b0, mem_req}, 32'd1);

        for (int i = 0; i < 3; i++) fetch(vecs[i].lat, vecs[i].stall, vecs[i].addr);

        // redirect during WAIT at 12: request stays up until mem_done, data dropped
        tick();
        br_taken = 1'b1; br_target = 32'h1002;
        tick();
        br_taken = 1'b0;
        chk("drop_req", {31'b0, mem_req}, 32'd1);
        chk("drop_addr", mem_addr, 32'hC);
        chk("drop_valid", {31'b0, if_valid}, 32'd0);
        tick();
        tick();
        chk("drop_req2", {31'b0, mem_req}, 32'd1);
        chk("drop_addr2", mem_addr, 32'hC);
        mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
        tick();
        mem_done = 1'b0;
        chk("drop_done_valid", {31'b0, if_valid}, 32'd0);
        chk("drop_done_req", {31'b0, mem_req}, 32'd0);
        tick();
        chk("tgt_req", {31'b0, mem_req}, 32'd1);
        chk("tgt_addr", mem_addr, 32'h1000);

        // redirect coinciding with mem_done
        tick();
        mem_done = 1'b1; mem_data = 32'h1234_5678; br_taken = 1'b1; br_target = 32'h40;
        tick();
        mem_done = 1'b0; br_taken = 1'b0;
        chk("brdone_valid", {31'b0, if_valid}, 32'd0);
        chk("brdone_req", {31'b0, mem_req}, 32'd0);
        tick();
        chk("brdone_valid2", {31'b0, if_valid}, 32'd0);
        chk("brdone_req2", {31'b0, mem_req}, 32'd1);
        chk("brdone_addr", mem_addr, 32'h40);

        // redirect from HOLD while stalled
        complete(32'h40);
        stall_in = 1'b1; br_taken = 1'b1; br_target = 32'h83;
        tick();
        stall_in = 1'b0; br_taken = 1'b0;
        chk("hold_br_valid", {31'b0, if_valid}, 32'd0);
        chk("hold_br_req", {31'b0, mem_req}, 32'd0);
        tick();
        chk("hold_br_req2", {31'b0, mem_req}, 32'd1);
        chk("hold_br_addr", mem_addr, 32'h80);

        // rdy=0 freezes state, ignoring done and redirect
        rdy = 1'b0; mem_done = 1'b1; mem_data = 32'hBAD0_BAD0; br_taken = 1'b1; br_target = 32'h200;
        tick();
        tick();
        chk("rdy_req", {31'b0, mem_req}, 32'd1);
        chk("rdy_addr", mem_addr, 32'h80);
        chk("rdy_valid", {31'b0, if_valid}, 32'd0);
        rdy = 1'b1; mem_done = 1'b0; br_taken = 1'b0;
        fetch(1, 0, 32'h80);

        // wrap-around at top of address space
        mem_done = 1'b1; mem_data = 32'h0; br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
        tick();
        mem_done = 1'b0; br_taken = 1'b0;
        chk("wrap_br_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        fetch(2, 0, 32'hFFFF_FFFC);
        fetch(1, 0, 32'h0);

        // async reset mid-WAIT
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_req", {31'b0, mem_req}, 32'd0);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_valid", {31'b0, if_valid}, 32'd0);
        #2 rst = 1'b1;
        tick();
        chk("restart_req", {31'b0, mem_req}, 32'd1);
        chk("restart_addr", mem_addr, 32'h0);

        // async reset while holding a live instruction
        complete(32'h0);
        stall_in = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_hold_valid", {31'b0, if_valid}, 32'd0);
        chk("arst_hold_inst", if_inst, 32'h0);
        chk("arst_hold_pc", if_pc, 32'h0);
        stall_in = 1'b0;
        #2 rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
